exc_pc_sequencer: RTL
=====================

Name: exc_pc_sequencer

Overview:
Multicycle sequencer that owns the PC-source mux selector and PC/EPC write strobes. It arbitrates between the main control unit's PC requests and exception entry. In IDLE it forwards the control unit's selector and write strobe unchanged. On an exception it takes over the mux for a fixed sequence: save EPC, fetch the handler byte from memory, load PC through the mux's memory-data input (selector 3'b101).

Parameters:
- MEM_LAT, 2, memory read latency in cycles (1..7); the address is held for exactly MEM_LAT cycles.
- VEC_BASE, 32'd253, address of the first exception vector byte; vector = VEC_BASE + cause index.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- ctrl_pc_src  in  3  PC-mux selector requested by the control unit
- ctrl_pc_write  in  1  PC write requested by the control unit
- exc_opcode  in  1  invalid opcode detected
- exc_overflow  in  1  ALU overflow detected
- exc_div0  in  1  divide by zero detected
- pc_in  in  32  current PC register value
- pc_src_sel  out  3  drives the PC-source mux selector
- pc_write  out  1  PC register write enable
- epc_write  out  1  EPC register write enable
- epc_data  out  32  value written to EPC (pc_in - 4)
- exc_mem_addr  out  32  memory address for the vector read
- exc_mem_sel  out  1  1 = memory address mux takes exc_mem_addr
- busy  out  1  high while the sequence owns the PC path; the control unit stalls
- done  out  1  one-cycle pulse in the cycle PC is loaded
- cause_out  out  32  cause register (see Optional Feature)

Behaviour:
- Reset (async, any state): state=IDLE; pc_src_sel=3'b000; pc_write=0; epc_write=0; exc_mem_sel=0; exc_mem_addr=0; busy=0; done=0; cause_out=0; wait counter=0.
- Cause index: opcode=0, overflow=1, div0=2. Fixed priority: opcode > overflow > div0.
- IDLE:
  - Combinational passthrough: pc_src_sel=ctrl_pc_src, pc_write=ctrl_pc_write.
  - If any exc_* is high at a clock edge: latch the index of the highest-priority cause and go to SAVE_EPC.
  - In that same detect cycle the passthrough is suppressed: pc_write=0, so the faulting PC is not overwritten.
- SAVE_EPC, 1 cycle:
  - epc_write=1, epc_data=pc_in-4 (32-bit, wraps modulo 2^32).
  - pc_write=0, busy=1.
  - Next state: READ.
- READ, MEM_LAT cycles:
  - exc_mem_sel=1, exc_mem_addr=VEC_BASE+index, held stable.
  - Counter counts MEM_LAT-1 down to 0.
  - Next state: LOAD.
- LOAD, 1 cycle:
  - pc_src_sel=3'b101, pc_write=1, done=1.
  - exc_mem_sel stays 1 so the read data is stable.
  - Next state: IDLE.
- busy=1 in SAVE_EPC, READ and LOAD; 0 in IDLE.
- Exception latency: request edge to PC load = 2+MEM_LAT cycles (4 with the defaults).
- exc_* inputs are ignored while busy; nothing is queued. The control unit must reassert a request if it still applies after done.
- Simultaneous exc_* and ctrl_pc_write in IDLE: the exception wins and the control write is dropped.
- ctrl_pc_src values 3'b110 and 3'b111 are forwarded unchanged. Selector decoding is the mux's responsibility.
- Reset asserted mid-sequence: immediate return to IDLE with all strobes low. No partial EPC or PC write is retried.
- All outputs other than the IDLE passthrough and epc_data are registered or decoded from state only. No combinational path from exc_* to epc_write.

Optional Feature:
- EXC_CAUSE_REG_EN defined:
  - cause_out[1:0] = index of the last taken exception, updated on entry to SAVE_EPC.
  - cause_out[15:8] = saturating count of taken exceptions; holds at 8'hFF.
  - All other bits 0; cleared by reset.
- Not defined: cause_out is tied to 32'd0 and no cause or counter flops are inferred.

Decomposition:
- Shared package (exc_pkg):
  - state encoding: IDLE, SAVE_EPC, READ, LOAD
  - cause index constants: CAUSE_OPCODE=2'd0, CAUSE_OVF=2'd1, CAUSE_DIV0=2'd2
  - PC-mux selector constants: SEL_PC4=3'b000, SEL_ALUOUT=3'b001, SEL_JUMP=3'b010, SEL_EPC=3'b011, SEL_SEXT=3'b100, SEL_MEM=3'b101
- One natural sub-module: exc_priority_enc, a combinational 3-to-2 priority encoder that also produces an "any" flag.

Test Plan:
- Idle passthrough: ctrl_pc_src=3'b010, ctrl_pc_write=1, no exc -> same cycle pc_src_sel=3'b010, pc_write=1, busy=0.
- Overflow entry (MEM_LAT=2): pc_in=32'h0000_0040, exc_overflow pulsed 1 cycle ->
  - cycle +1: epc_write=1, epc_data=32'h3C
  - cycles +2..+3: exc_mem_addr=254, exc_mem_sel=1
  - cycle +4: pc_src_sel=3'b101, pc_write=1, done=1
  - cycle +5: busy=0
- Priority: exc_opcode=1, exc_div0=1 together -> exc_mem_addr=253; with EXC_CAUSE_REG_EN, cause_out[1:0]=0.
- Busy masking: div0 taken, then exc_opcode=1 during READ -> sequence finishes with addr 255; no second entry; count increments by exactly 1.
- Reset mid-sequence: assert reset during READ -> all outputs reach reset values asynchronously; release with no exc -> IDLE passthrough, no stray pc_write.
- Edge cases:
  - pc_in=0 -> epc_data=32'hFFFF_FFFC.
  - 260 exceptions with EXC_CAUSE_REG_EN -> cause_out[15:8]=8'hFF.

Source files
------------

// File: rtl/exc_pkg.sv
// rtl/exc_pkg.sv - shared state, cause and PC-mux selector encodings for the exception sequencer
package exc_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SAVE_EPC = 2'd1,
    READ     = 2'd2,
    LOAD     = 2'd3
  } state_t;

  localparam logic [1:0] CAUSE_OPCODE = 2'd0;
  localparam logic [1:0] CAUSE_OVF    = 2'd1;
  localparam logic [1:0] CAUSE_DIV0   = 2'd2;

  localparam logic [2:0] SEL_PC4    = 3'b000;
  localparam logic [2:0] SEL_ALUOUT = 3'b001;
  localparam logic [2:0] SEL_JUMP   = 3'b010;
  localparam logic [2:0] SEL_EPC    = 3'b011;
  localparam logic [2:0] SEL_SEXT   = 3'b100;
  localparam logic [2:0] SEL_MEM    = 3'b101;

  function automatic logic [31:0] vec_addr(input logic [31:0] base, input logic [1:0] idx);
    return base + {30'd0, idx};
  endfunction

endpackage

// File: rtl/exc_priority_enc.sv
// rtl/exc_priority_enc.sv - fixed-priority cause encoder (opcode > overflow > div0) with any flag
module exc_priority_enc
  import exc_pkg::*;
(
  input  logic       exc_opcode,
  input  logic       exc_overflow,
  input  logic       exc_div0,
  output logic [1:0] idx,
  output logic       any
);

  always_comb begin
    idx = CAUSE_OPCODE;
    if (exc_opcode)        idx = CAUSE_OPCODE;
    else if (exc_overflow) idx = CAUSE_OVF;
    else if (exc_div0)     idx = CAUSE_DIV0;
  end

  assign any = exc_opcode | exc_overflow | exc_div0;

endmodule

// File: rtl/exc_pc_sequencer.sv
// rtl/exc_pc_sequencer.sv - PC/EPC write sequencer for exception entry; EXC_CAUSE_REG_EN adds cause/count register
module exc_pc_sequencer
  import exc_pkg::*;
#(
  parameter int          MEM_LAT  = 2,
  parameter logic [31:0] VEC_BASE = 32'd253
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  ctrl_pc_src,
  input  logic        ctrl_pc_write,
  input  logic        exc_opcode,
  input  logic        exc_overflow,
  input  logic        exc_div0,
  input  logic [31:0] pc_in,
  output logic [2:0]  pc_src_sel,
  output logic        pc_write,
  output logic        epc_write,
  output logic [31:0] epc_data,
  output logic [31:0] exc_mem_addr,
  output logic        exc_mem_sel,
  output logic        busy,
  output logic        done,
  output logic [31:0] cause_out
);

  localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

  state_t     state;
  logic [2:0] wait_cnt;
  logic [1:0] exc_idx;
  logic       exc_any;

  exc_priority_enc u_enc (
    .exc_opcode   (exc_opcode),
    .exc_overflow (exc_overflow),
    .exc_div0     (exc_div0),
    .idx          (exc_idx),
    .any          (exc_any)
  );

  assign epc_data = pc_in - 32'd4;

  // Only IDLE forwards the control unit; the detect cycle drops its write so the faulting PC survives.
  always_comb begin
    pc_src_sel = done ? SEL_MEM : SEL_PC4;
    pc_write   = done;
    if (state == IDLE) begin
      pc_src_sel = ctrl_pc_src;
      pc_write   = ctrl_pc_write & ~exc_any;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      wait_cnt     <= 3'd0;
      epc_write    <= 1'b0;
      exc_mem_sel  <= 1'b0;
      exc_mem_addr <= 32'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (exc_any) begin
            state        <= SAVE_EPC;
            epc_write    <= 1'b1;
            busy         <= 1'b1;
            exc_mem_addr <= vec_addr(VEC_BASE, exc_idx);
          end
        end
        SAVE_EPC: begin
          state       <= READ;
          epc_write   <= 1'b0;
          exc_mem_sel <= 1'b1;
          wait_cnt    <= LAT_M1;
        end
        READ: begin
          if (wait_cnt == 3'd0) begin
            state <= LOAD;
            done  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        LOAD: begin
          state       <= IDLE;
          done        <= 1'b0;
          busy        <= 1'b0;
          exc_mem_sel <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef EXC_CAUSE_REG_EN
  logic [1:0] last_cause;
  logic [7:0] exc_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_cause <= 2'd0;
      exc_count  <= 8'd0;
    end else if (state == IDLE && exc_any) begin
      last_cause <= exc_idx;
      if (exc_count != 8'hFF) exc_count <= exc_count + 8'd1;
    end
  end

  assign cause_out = {16'd0, exc_count, 6'd0, last_cause};
`else
  assign cause_out = 32'd0;
`endif

endmodule
